menu_pago_n: RTL and testbench

- Parametrised successor of the two-option payment menu FSM.
- Lets the user browse N_OPT payment methods with advance/back buttons, select one, then waits for payment confirmation.
- Issues change and receipt phases, then returns to idle on cancel.
- Adds configurable option count, wrap-around browsing, inactivity timeout and a payment-confirm handshake. Sits between the debounced button front end and the payment/receipt peripherals.

---
 rtl/menu_pkg.sv | 36 +++
 rtl/menu_cursor.sv | 52 +++++
 rtl/menu_pago_n.sv | 198 +++++++++++++++++++
 tb/tb_menu_pago_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// -----------------------------------------------------------------------------
// menu_pkg
// Shared definitions for the parametrised payment menu (menu_pago_n):
//   - state_t  : FSM state encoding (IDLE, BROWSE, WAIT_PAY, CHANGE, RECEIPT, FIN)
//   - STATE_W  : width of the state register
//   - MAX_OPT  : largest supported option count
//   - IDX_W    : index width able to address MAX_OPT options
//   - TW       : inactivity counter width
//   - onehot() : one-hot decode of an option index
// -----------------------------------------------------------------------------
package menu_pkg;

   localparam int STATE_W = 3;
   localparam int MAX_OPT = 16;
   localparam int IDX_W   = 4;
   localparam int TW      = 20;

   // Encodings 6 and 7 are unused; the FSM steers them back to IDLE.
   typedef enum logic [STATE_W-1:0] {
      IDLE     = 3'd0,
      BROWSE   = 3'd1,
      WAIT_PAY = 3'd2,
      CHANGE   = 3'd3,
      RECEIPT  = 3'd4,
      FIN      = 3'd5
   } state_t;

   // Full-width one-hot; callers size-cast the result down to N_OPT bits.
   function automatic logic [MAX_OPT-1:0] onehot(input logic [IDX_W-1:0] i_idx);
      logic [MAX_OPT-1:0] v;
      v        = '0;
      v[i_idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/menu_cursor.sv
// -----------------------------------------------------------------------------
// menu_cursor
// Up/down option cursor with synchronous clear. At either end it saturates
// (WRAP=0) or wraps to the opposite end (WRAP=1).
// Ports:
//   i_clk     system clock
//   i_reset   synchronous active-high reset
//   i_clr     synchronous clear to option 0
//   i_inc     step forward one option
//   i_dec     step back one option (i_inc wins if both are high)
//   o_cursor  current option index, 0..N_OPT-1
// -----------------------------------------------------------------------------
module menu_cursor #(
   parameter int N_OPT = 4,
   parameter int WRAP  = 0,
   parameter int CW    = $clog2(N_OPT)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clr,
   input  logic          i_inc,
   input  logic          i_dec,
   output logic [CW-1:0] o_cursor
);

   localparam logic [CW-1:0] LAST = CW'(N_OPT - 1);

   logic [CW-1:0] r_cursor;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_cursor <= '0;
      end else if (i_inc) begin
         if (r_cursor == LAST) begin
            r_cursor <= (WRAP != 0) ? '0 : LAST;
         end else begin
            r_cursor <= r_cursor + CW'(1);
         end
      end else if (i_dec) begin
         if (r_cursor == '0) begin
            r_cursor <= (WRAP != 0) ? LAST : '0;
         end else begin
            r_cursor <= r_cursor - CW'(1);
         end
      end
   end

   assign o_cursor = r_cursor;

endmodule

// File: rtl/menu_pago_n.sv
// -----------------------------------------------------------------------------
// menu_pago_n
// Parametrised payment-method menu. The user browses N_OPT options, selects
// one, waits for the downstream payment confirmation, then walks through an
// optional change phase (cash option only) and a receipt phase before parking
// in FIN until cancel. BROWSE and WAIT_PAY abandon to IDLE after TMO_CYC idle
// cycles. Outputs are Moore-decoded from the state register.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset (overrides everything)
//   i_act      menu enable; starts browsing from IDLE
//   i_ad       advance button pulse
//   i_at       back button pulse
//   i_sel      select button pulse
//   i_clc      cancel/clear button pulse
//   i_pay_ok   payment accepted pulse from downstream
//   o_cursor   highlighted option
//   o_opt_sel  one-hot selected option, non-zero only in WAIT_PAY
//   o_chg_en   high during CHANGE
//   o_rcpt     high during RECEIPT (one cycle)
//   o_busy     high in every state except IDLE
//   o_tmo      one-cycle pulse on the first IDLE cycle after a timeout
// -----------------------------------------------------------------------------
module menu_pago_n
   import menu_pkg::*;
#(
   parameter int  N_OPT    = 4,
   parameter int  WRAP     = 0,
   parameter int  CASH_IDX = 0,
   parameter int  TMO_CYC  = 1000,
   localparam int CW       = $clog2(N_OPT)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_act,
   input  logic             i_ad,
   input  logic             i_at,
   input  logic             i_sel,
   input  logic             i_clc,
   input  logic             i_pay_ok,
   output logic [CW-1:0]    o_cursor,
   output logic [N_OPT-1:0] o_opt_sel,
   output logic             o_chg_en,
   output logic             o_rcpt,
   output logic             o_busy,
   output logic             o_tmo
);

   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
   localparam logic [CW-1:0] CASH     = CW'(CASH_IDX);

   state_t             r_state;
   logic [TW-1:0]      r_tmo_cnt;
   logic               r_tmo;
   logic [N_OPT-1:0]   r_opt_sel;
   logic [CW-1:0]      w_cursor;

   state_t             w_state_next;
   logic               w_inc;
   logic               w_dec;
   logic               w_cur_clr;
   logic               w_load_sel;
   logic               w_tmo_fire;
   logic               w_event;
   logic               w_counting;
   logic               w_expired;
   logic               w_tmo_clr;

   // Any button or confirmation counts as activity, even when the current
   // state otherwise ignores it.
   assign w_event    = i_ad | i_at | i_sel | i_clc | i_pay_ok;
   assign w_counting = (r_state == BROWSE) || (r_state == WAIT_PAY);
   assign w_expired  = w_counting && (r_tmo_cnt == TMO_LAST) && !w_event;

   // Cursor returns to option 0 whenever the menu heads back to IDLE, so
   // IDLE always presents cursor 0 and browsing always starts there.
   assign w_cur_clr  = (w_state_next == IDLE);

   // Counter restarts on entry to any state, on activity, and outside the
   // timed states.
   assign w_tmo_clr  = (w_state_next != r_state) || w_event || !w_counting;

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave a value unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_inc        = 1'b0;
      w_dec        = 1'b0;
      w_load_sel   = 1'b0;
      w_tmo_fire   = 1'b0;
      o_busy       = 1'b1;
      o_chg_en     = 1'b0;
      o_rcpt       = 1'b0;
      o_opt_sel    = '0;

      case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_act) begin
               w_state_next = BROWSE;
            end
         end

         // Priority clc > ad > at > sel; timeout only when nothing arrived.
         BROWSE: begin
            if (i_clc) begin
               w_state_next = IDLE;
            end else if (i_ad) begin
               w_inc = 1'b1;
            end else if (i_at) begin
               w_dec = 1'b1;
            end else if (i_sel) begin
               w_state_next = WAIT_PAY;
               w_load_sel   = 1'b1;
            end else if (w_expired) begin
               w_state_next = IDLE;
               w_tmo_fire   = 1'b1;
            end
         end

         WAIT_PAY: begin
            o_opt_sel = r_opt_sel;
            if (i_clc) begin
               w_state_next = BROWSE;
            end else if (i_pay_ok) begin
               w_state_next = (w_cursor == CASH) ? CHANGE : RECEIPT;
            end else if (w_expired) begin
               w_state_next = IDLE;
               w_tmo_fire   = 1'b1;
            end
         end

         CHANGE: begin
            o_chg_en     = 1'b1;
            w_state_next = RECEIPT;
         end

         RECEIPT: begin
            o_rcpt       = 1'b1;
            w_state_next = FIN;
         end

         FIN: begin
            if (i_clc) begin
               w_state_next = IDLE;
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, timeout and selection registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_tmo_cnt <= '0;
         r_tmo     <= 1'b0;
         r_opt_sel <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_tmo_clr) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         end
         // Registered so the pulse lands on the first IDLE cycle.
         r_tmo <= w_tmo_fire;
         if (w_load_sel) begin
            r_opt_sel <= N_OPT'(onehot(IDX_W'(w_cursor)));
         end
      end
   end

   menu_cursor #(
      .N_OPT (N_OPT),
      .WRAP  (WRAP),
      .CW    (CW)
   ) u_cursor (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clr    (w_cur_clr),
      .i_inc    (w_inc),
      .i_dec    (w_dec),
      .o_cursor (w_cursor)
   );

   assign o_cursor = w_cursor;
   assign o_tmo    = r_tmo;

endmodule

// File: tb/tb_menu_pago_n.sv
// -----------------------------------------------------------------------------
// tb_menu_pago_n
// Two instances share one stimulus stream: u_sat (WRAP=0) and u_wrap (WRAP=1),
// both N_OPT=4, CASH_IDX=0, TMO_CYC=8. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_menu_pago_n;

   logic       clk = 1'b0;
   logic       reset, act, ad, at, sel, clc, pay_ok;

   logic [1:0] s_cursor, w_cursor;
   logic [3:0] s_opt_sel, w_opt_sel;
   logic       s_chg_en, s_rcpt, s_busy, s_tmo;
   logic       w_chg_en, w_rcpt, w_busy, w_tmo;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   menu_pago_n #(.N_OPT(4), .WRAP(0), .CASH_IDX(0), .TMO_CYC(8)) u_sat (
      .i_clk(clk), .i_reset(reset), .i_act(act), .i_ad(ad), .i_at(at),
      .i_sel(sel), .i_clc(clc), .i_pay_ok(pay_ok),
      .o_cursor(s_cursor), .o_opt_sel(s_opt_sel), .o_chg_en(s_chg_en),
      .o_rcpt(s_rcpt), .o_busy(s_busy), .o_tmo(s_tmo)
   );

   menu_pago_n #(.N_OPT(4), .WRAP(1), .CASH_IDX(0), .TMO_CYC(8)) u_wrap (
      .i_clk(clk), .i_reset(reset), .i_act(act), .i_ad(ad), .i_at(at),
      .i_sel(sel), .i_clc(clc), .i_pay_ok(pay_ok),
      .o_cursor(w_cursor), .o_opt_sel(w_opt_sel), .o_chg_en(w_chg_en),
      .o_rcpt(w_rcpt), .o_busy(w_busy), .o_tmo(w_tmo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse one button for one edge: 0=ad 1=at 2=sel 3=clc 4=pay_ok 5=act
   task automatic press(input int which);
      case (which)
         0: ad     = 1'b1;
         1: at     = 1'b1;
         2: sel    = 1'b1;
         3: clc    = 1'b1;
         4: pay_ok = 1'b1;
         default: act = 1'b1;
      endcase
      tick();
      {ad, at, sel, clc, pay_ok, act} = '0;
   endtask

   // Status of both instances: {busy, chg_en, rcpt, tmo}
   task automatic check_both(input string tag, input logic [3:0] exp);
      check({tag, "/sat"},  {28'd0, s_busy, s_chg_en, s_rcpt, s_tmo}, {28'd0, exp});
      check({tag, "/wrap"}, {28'd0, w_busy, w_chg_en, w_rcpt, w_tmo}, {28'd0, exp});
   endtask

   localparam logic [1:0] SAT_AD[5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
   localparam logic [1:0] WRP_AD[5]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
   localparam logic [1:0] SAT_AT[4]  = '{2'd2, 2'd1, 2'd0, 2'd0};
   localparam logic [1:0] WRP_AT[4]  = '{2'd0, 2'd3, 2'd2, 2'd1};

   initial begin
      reset = 1'b1; act = 1'b1;
      {ad, at, sel, clc, pay_ok} = '0;

      // Reset held with act=1 keeps both in IDLE
      tick(); tick();
      check_both("reset_status", 4'b0000);
      check("reset_cursor", {30'd0, s_cursor}, 32'd0);
      check("reset_opt_sel", {28'd0, w_opt_sel}, 32'd0);

      // Enter BROWSE
      reset = 1'b0;
      tick();
      act = 1'b0;
      check_both("browse_entry", 4'b1000);
      check("browse_cursor0", {30'd0, w_cursor}, 32'd0);

      // ad x5 then at x4: saturating vs wrapping
      for (int i = 0; i < 5; i++) begin
         press(0);
         check($sformatf("ad%0d/sat", i),  {30'd0, s_cursor}, {30'd0, SAT_AD[i]});
         check($sformatf("ad%0d/wrap", i), {30'd0, w_cursor}, {30'd0, WRP_AD[i]});
      end
      for (int i = 0; i < 4; i++) begin
         press(1);
         check($sformatf("at%0d/sat", i),  {30'd0, s_cursor}, {30'd0, SAT_AT[i]});
         check($sformatf("at%0d/wrap", i), {30'd0, w_cursor}, {30'd0, WRP_AT[i]});
      end

      // clc in BROWSE -> IDLE, cursor 0
      press(3);
      check_both("browse_clc", 4'b0000);
      check("browse_clc_cursor", {30'd0, w_cursor}, 32'd0);

      // act, at -> wrap 3 / sat 0; ad -> wrap 0 / sat 1
      press(5);
      press(1);
      check("wrap_back", {30'd0, w_cursor}, 32'd3);
      check("sat_back",  {30'd0, s_cursor}, 32'd0);
      press(0);
      check("wrap_fwd", {30'd0, w_cursor}, 32'd0);
      check("sat_fwd",  {30'd0, s_cursor}, 32'd1);

      // ad, ad, sel -> WAIT_PAY (wrap on option 2, sat on option 3)
      press(0); press(0);
      check("opt_sel_before_sel", {28'd0, w_opt_sel}, 32'd0);
      press(2);
      check("wait_opt_sel/wrap", {28'd0, w_opt_sel}, 32'b0100);
      check("wait_opt_sel/sat",  {28'd0, s_opt_sel}, 32'b1000);
      check_both("wait_status", 4'b1000);

      // ad/at ignored in WAIT_PAY
      press(0);
      check("wait_ad_ignored", {30'd0, w_cursor}, 32'd2);
      check("wait_ad_opt_sel", {28'd0, w_opt_sel}, 32'b0100);

      // clc together with pay_ok -> BROWSE, cursor kept, no receipt
      clc = 1'b1; pay_ok = 1'b1;
      tick();
      clc = 1'b0; pay_ok = 1'b0;
      check_both("clc_pay_ok", 4'b1000);
      check("clc_pay_ok_cursor", {30'd0, w_cursor}, 32'd2);
      check("clc_pay_ok_opt_sel", {28'd0, w_opt_sel}, 32'd0);
      tick();
      check_both("clc_pay_ok_norcpt", 4'b1000);

      // Card path: sel, pay_ok -> RECEIPT directly, then FIN
      press(2);
      press(4);
      check_both("card_rcpt", 4'b1010);
      tick();
      check_both("card_fin", 4'b1000);

      // FIN ignores ad, leaves on clc
      press(0);
      check("fin_ad_ignored", {30'd0, w_cursor}, 32'd2);
      check_both("fin_hold", 4'b1000);
      press(3);
      check_both("fin_clc", 4'b0000);
      check("fin_clc_cursor", {30'd0, w_cursor}, 32'd0);

      // Cash path: option 0 -> CHANGE, RECEIPT, FIN
      press(5);
      press(2);
      check("cash_opt_sel", {28'd0, s_opt_sel}, 32'b0001);
      press(4);
      check_both("cash_change", 4'b1100);
      tick();
      check_both("cash_rcpt", 4'b1010);
      tick();
      check_both("cash_fin", 4'b1000);
      press(3);
      check_both("cash_idle", 4'b0000);
      check("cash_idle_cursor", {30'd0, s_cursor}, 32'd0);

      // Timeout: 8 idle cycles in BROWSE
      press(5);
      for (int i = 0; i < 7; i++) tick();
      check_both("tmo_not_yet", 4'b1000);
      tick();
      check_both("tmo_fire", 4'b0001);
      tick();
      check_both("tmo_one_cycle", 4'b0000);

      // ad on the expiry cycle cancels the timeout
      press(5);
      for (int i = 0; i < 7; i++) tick();
      press(0);
      check_both("tmo_cancel", 4'b1000);
      check("tmo_cancel_cursor", {30'd0, w_cursor}, 32'd1);
      for (int i = 0; i < 7; i++) tick();
      check_both("tmo_rearm_not_yet", 4'b1000);
      tick();
      check_both("tmo_rearm_fire", 4'b0001);
      check("tmo_rearm_cursor", {30'd0, w_cursor}, 32'd0);

      // Timeout in WAIT_PAY
      press(5);
      press(2);
      for (int i = 0; i < 7; i++) tick();
      check("wait_tmo_not_yet", {28'd0, s_opt_sel}, 32'b0001);
      tick();
      check_both("wait_tmo_fire", 4'b0001);

      // Reset during CHANGE
      tick();
      press(5);
      press(2);
      press(4);
      check_both("pre_reset_change", 4'b1100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_both("reset_in_change", 4'b0000);
      check("reset_in_change_cursor", {30'd0, s_cursor}, 32'd0);
      check("reset_in_change_opt", {28'd0, s_opt_sel}, 32'd0);
      tick();
      check_both("after_reset_idle", 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
